// File: rtl/watch_button_ctrl.sv
// Four-channel button conditioner: 2-FF sync, debounce FSM and up/dn conflict blocking.
// Define WATCH_BTN_AUTO_REPEAT_EN to add hold-to-auto-repeat pulses.
module watch_button_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 655,
   parameter int unsigned REPEAT_DELAY    = 16384,
   parameter int unsigned REPEAT_PERIOD   = 3277,
   parameter int unsigned CNT_W           = 15
) (
   input  logic Clk,
   input  logic reset,
   input  logic btn_min_up,
   input  logic btn_min_dn,
   input  logic btn_hr_up,
   input  logic btn_hr_dn,
   output logic min_inc,
   output logic min_dec,
   output logic hour_inc,
   output logic hour_dec,
   output logic setting_active
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_DEB_PRESS = 2'd1;
   localparam logic [1:0] ST_HELD      = 2'd2;
   localparam logic [1:0] ST_DEB_REL   = 2'd3;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

`ifdef WATCH_BTN_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_DELAY - 1);
   // Reloading here makes the next hit land REPEAT_PERIOD cycles later.
   localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

   // Channel order: 0 min_up, 1 min_dn, 2 hr_up, 3 hr_dn; the opposing channel is index ^ 1.
   logic [3:0] btn_raw;
   logic [3:0] sync1_q, sync2_q;
   logic [3:0] accept, active, busy, pulse;
   logic       setting_q;

   assign btn_raw = {btn_hr_dn, btn_hr_up, btn_min_dn, btn_min_up};

   always_ff @(posedge Clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_ch
      localparam int unsigned OPP = i ^ 1;

      logic [1:0]       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             s;
      logic             accept_c, repeat_c;
      logic             blocked_q, blocked_d;
      logic             pulse_q, pulse_d;

      assign s = sync2_q[i];

      always_comb begin
         state_d  = state_q;
         cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
         accept_c = 1'b0;
         repeat_c = 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (s) state_d = ST_DEB_PRESS;
            end
            ST_DEB_PRESS: begin
               if (!s) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d  = ST_HELD;
                  cnt_d    = '0;
                  accept_c = 1'b1;
               end
            end
            ST_HELD: begin
               if (!s) begin
                  state_d = ST_DEB_REL;
                  cnt_d   = '0;
               end
`ifdef WATCH_BTN_AUTO_REPEAT_EN
               else if (cnt_q == REP_LAST) begin
                  repeat_c = 1'b1;
                  cnt_d    = REP_RELOAD;
               end
`endif
            end
            ST_DEB_REL: begin
               if (s) begin
                  state_d = ST_HELD;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
         endcase
      end

      assign accept[i] = accept_c;
      assign active[i] = (state_q == ST_HELD) || (state_q == ST_DEB_REL);
      assign busy[i]   = (state_q != ST_IDLE);
      assign pulse[i]  = pulse_q;

      // blocked: the opposing channel was accepted first (or together) and is still active.
      always_comb begin
         if (accept_c) begin
            blocked_d = active[OPP] || accept[OPP];
         end else if (!active[OPP]) begin
            blocked_d = 1'b0;
         end else begin
            blocked_d = blocked_q;
         end
         pulse_d = (accept_c && !active[OPP] && !accept[OPP]) ||
                   (repeat_c && !(blocked_q && active[OPP]));
      end

      always_ff @(posedge Clk) begin
         if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            blocked_q <= 1'b0;
            pulse_q   <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
            pulse_q   <= pulse_d;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) setting_q <= 1'b0;
      else       setting_q <= |busy;
   end

   assign min_inc        = pulse[0];
   assign min_dec        = pulse[1];
   assign hour_inc       = pulse[2];
   assign hour_dec       = pulse[3];
   assign setting_active = setting_q;

endmodule
